joy_dir_filter: RTL and testbench



---
 rtl/joy_pkg.sv | 53 +++++
 rtl/joy_dir_filter_if.sv | 25 ++
 rtl/joy_dir_chan.sv | 111 +++++++++++
 rtl/joy_dir_filter.sv | 31 +++
 tb/tb_joy_dir_filter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/joy_pkg.sv
// Shared types and helpers for the joystick direction filter.
// Holds the filter mode enum, direction bit indices, the 4-bit direction
// type, and the priority / SOCD helper functions used by every channel.
package joy_pkg;

    // Filter mode applied to every non-bypassed player
    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_LAST  = 2'd1,
        MODE_FIRST = 2'd2,
        MODE_SOCD  = 2'd3
    } joy_mode_e;

    localparam int unsigned DIR_W     = 4;
    localparam int unsigned DIR_UP    = 3;
    localparam int unsigned DIR_DOWN  = 2;
    localparam int unsigned DIR_LEFT  = 1;
    localparam int unsigned DIR_RIGHT = 0;

    // {up, down, left, right}
    typedef logic [DIR_W-1:0] joy_dir_t;

    // One-hot of the highest-priority set bit (up > down > left > right), or zero
    function automatic joy_dir_t prio_onehot(input joy_dir_t d);
        joy_dir_t r;
        r = '0;
        if (d[DIR_UP])
            r[DIR_UP] = 1'b1;
        else if (d[DIR_DOWN])
            r[DIR_DOWN] = 1'b1;
        else if (d[DIR_LEFT])
            r[DIR_LEFT] = 1'b1;
        else if (d[DIR_RIGHT])
            r[DIR_RIGHT] = 1'b1;
        return r;
    endfunction

    // Opposing directions held together cancel; diagonals pass unchanged
    function automatic joy_dir_t socd_filter(input joy_dir_t d);
        joy_dir_t r;
        r = d;
        if (d[DIR_UP] && d[DIR_DOWN]) begin
            r[DIR_UP]   = 1'b0;
            r[DIR_DOWN] = 1'b0;
        end
        if (d[DIR_LEFT] && d[DIR_RIGHT]) begin
            r[DIR_LEFT]  = 1'b0;
            r[DIR_RIGHT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/joy_dir_filter_if.sv
// Bus bundle for joy_dir_filter.
//   joy_in  [4*NUM_PLAYERS] raw directions, player p at [4p+3:4p]
//   mode    [2]             filter mode for all players
//   dis     [NUM_PLAYERS]   per-player bypass (forces pass-through)
//   joy_out [4*NUM_PLAYERS] filtered directions, same layout as joy_in
//   chg     [NUM_PLAYERS]   one-cycle pulse when a player's joy_out changes
interface joy_dir_filter_if #(
    parameter int unsigned NUM_PLAYERS = 2
);
    logic [4*NUM_PLAYERS-1:0] joy_in;
    logic [1:0]               mode;
    logic [NUM_PLAYERS-1:0]   dis;
    logic [4*NUM_PLAYERS-1:0] joy_out;
    logic [NUM_PLAYERS-1:0]   chg;

    modport master (
        output joy_in, mode, dis,
        input  joy_out, chg
    );

    modport slave (
        input  joy_in, mode, dis,
        output joy_out, chg
    );
endinterface

// File: rtl/joy_dir_chan.sv
// One joystick channel: synchroniser, debouncer and direction filter.
//   clk      sole clock
//   reset_n  synchronous active-low reset
//   joy_in   raw {up,down,left,right}, asynchronous
//   mode     filter mode (PASS/LAST/FIRST/SOCD), quasi-static
//   dis      bypass, forces pass-through
//   joy_out  filtered directions, registered
//   chg      registered pulse when joy_out changes
module joy_dir_chan
    import joy_pkg::*;
#(
    parameter int unsigned DEB_LEN = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  joy_dir_t joy_in,
    input  logic [1:0] mode,
    input  logic     dis,
    output joy_dir_t joy_out,
    output logic     chg
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LEN - 1);
    localparam joy_dir_t MASK_ALL    = 4'b1111;

    joy_dir_t         s1, s2, s3;
    joy_dir_t         deb, deb_prev;
    joy_dir_t         mask;
    logic [CNT_W-1:0] cnt;
    joy_mode_e        mode_q;

    joy_dir_t         deb_nxt, mask_nxt, out_nxt, new_press, mask_eff;
    logic [CNT_W-1:0] cnt_nxt;
    logic             chg_nxt, mode_chg;
    joy_mode_e        mode_cur;

    // Debounce, mask update and output selection
    always_comb begin
        deb_nxt   = deb;
        cnt_nxt   = cnt;
        mask_nxt  = mask;
        out_nxt   = joy_out;
        mode_cur  = joy_mode_e'(mode);
        mode_chg  = (mode_cur != mode_q);
        new_press = deb & ~deb_prev;
        // A mode change or bypass makes the current mask irrelevant immediately
        mask_eff  = (dis || mode_chg) ? MASK_ALL : mask;

        // Accept s2 only after DEB_LEN consecutive stable cycles differing from deb
        if ((s2 != s3) || (s2 == deb)) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
            deb_nxt = s2;
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        if (dis || (mode_cur == MODE_PASS)) begin
            out_nxt  = deb;
            mask_nxt = MASK_ALL;
        end else if (mode_cur == MODE_SOCD) begin
            out_nxt  = socd_filter(deb);
            mask_nxt = MASK_ALL;
        end else begin
            // Output follows the mask in force this cycle; a freshly chosen mask shows next cycle
            out_nxt = (mask_eff == MASK_ALL) ? prio_onehot(deb) : (deb & mask_eff);
            if (mode_chg) begin
                mask_nxt = MASK_ALL;
            end else if ((new_press != '0) &&
                         ((mask_eff == MASK_ALL) || (mode_cur == MODE_LAST))) begin
                mask_nxt = prio_onehot(new_press);
            end else if ((mask_eff != MASK_ALL) && ((deb & mask_eff) == '0)) begin
                mask_nxt = MASK_ALL;
            end else begin
                mask_nxt = mask_eff;
            end
        end

        chg_nxt = (out_nxt != joy_out);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            deb      <= '0;
            deb_prev <= '0;
            cnt      <= '0;
            mask     <= MASK_ALL;
            mode_q   <= MODE_PASS;
            joy_out  <= '0;
            chg      <= 1'b0;
        end else begin
            s1       <= joy_in;
            s2       <= s1;
            s3       <= s2;
            deb      <= deb_nxt;
            deb_prev <= deb;
            cnt      <= cnt_nxt;
            mask     <= mask_nxt;
            mode_q   <= mode_cur;
            joy_out  <= out_nxt;
            chg      <= chg_nxt;
        end
    end

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction filter; one joy_dir_chan per player.
//   clk      sole clock
//   reset_n  synchronous active-low reset
//   bus      joy_dir_filter_if.slave: joy_in, mode, dis in; joy_out, chg out
module joy_dir_filter
    import joy_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned DEB_LEN     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    joy_dir_filter_if.slave    bus
);

    // Slice the buses per player
    for (genvar p = 0; p < int'(NUM_PLAYERS); p++) begin : g_chan
        joy_dir_chan #(
            .DEB_LEN (DEB_LEN)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .joy_in  (bus.joy_in[DIR_W*p +: DIR_W]),
            .mode    (bus.mode),
            .dis     (bus.dis[p]),
            .joy_out (bus.joy_out[DIR_W*p +: DIR_W]),
            .chg     (bus.chg[p])
        );
    end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Self-checking bench for joy_dir_filter (3 players, DEB_LEN = 4).
module tb_joy_dir_filter;

    localparam int NP = 3;
    localparam int DL = 4;
    localparam int HD = DL + 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    joy_dir_filter_if #(.NUM_PLAYERS(NP)) bus ();

    joy_dir_filter #(
        .NUM_PLAYERS (NP),
        .DEB_LEN     (DL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // raw[p][k]: input sampled k+1 edges ago (k = 0 is the previous edge)
    logic [3:0] raw [NP][HD];
    logic [3:0] m_deb [NP];
    logic [3:0] m_dprev [NP];
    logic [3:0] m_out [NP];
    int         m_sel [NP];     // selected direction index, -1 = none (all allowed)
    logic [NP-1:0] m_chg;
    logic [1:0] m_mode_q;

    logic [3:0] t_d, t_nw, t_o, t_ndeb;
    int         t_s, t_sn;
    bit         t_mc, t_stab;

    function automatic int hi_idx(input logic [3:0] d);
        for (int i = 3; i >= 0; i--)
            if (d[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] hi_bit(input logic [3:0] d);
        int i;
        i = hi_idx(d);
        return (i < 0) ? 4'b0000 : 4'(1 << i);
    endfunction

    function automatic logic [3:0] socd(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[3] && d[2]) r[3:2] = 2'b00;
        if (d[1] && d[0]) r[1:0] = 2'b00;
        return r;
    endfunction

    initial begin : model
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                for (int p = 0; p < NP; p++) begin
                    m_deb[p] = '0; m_dprev[p] = '0; m_out[p] = '0; m_sel[p] = -1;
                    for (int k = 0; k < HD; k++) raw[p][k] = '0;
                end
                m_chg    = '0;
                m_mode_q = 2'd0;
            end else begin
                for (int p = 0; p < NP; p++) begin
                    t_d  = m_deb[p];
                    t_nw = t_d & ~m_dprev[p];
                    t_mc = (bus.mode != m_mode_q);
                    if (bus.dis[p] || bus.mode == 2'd0) begin
                        t_o = t_d; t_sn = -1;
                    end else if (bus.mode == 2'd3) begin
                        t_o = socd(t_d); t_sn = -1;
                    end else begin
                        t_s = t_mc ? -1 : m_sel[p];
                        t_o = (t_s < 0) ? hi_bit(t_d) : (t_d & 4'(1 << t_s));
                        if (t_mc)
                            t_sn = -1;
                        else if (t_nw != 0 && (t_s < 0 || bus.mode == 2'd1))
                            t_sn = hi_idx(t_nw);
                        else if (t_s >= 0 && !t_d[t_s])
                            t_sn = -1;
                        else
                            t_sn = t_s;
                    end
                    // accepted once the synchronised value has held for DL+1 samples
                    t_stab = 1'b1;
                    for (int k = 2; k <= DL + 1; k++)
                        if (raw[p][k] != raw[p][1]) t_stab = 1'b0;
                    t_ndeb = (t_stab && raw[p][1] != t_d) ? raw[p][1] : t_d;

                    m_chg[p]   = (t_o != m_out[p]);
                    m_out[p]   = t_o;
                    m_sel[p]   = t_sn;
                    m_dprev[p] = t_d;
                    m_deb[p]   = t_ndeb;
                    for (int k = HD - 1; k > 0; k--) raw[p][k] = raw[p][k-1];
                    raw[p][0] = bus.joy_in[4*p +: 4];
                end
                m_mode_q = bus.mode;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic [4*NP-1:0] m_vec;
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int p = 0; p < NP; p++) m_vec[4*p +: 4] = m_out[p];
                check("model_joy_out", 32'(bus.joy_out), 32'(m_vec));
                check("model_chg", 32'(bus.chg), 32'(m_chg));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_p(input int p, input logic [3:0] v);
        bus.joy_in[4*p +: 4] = v;
    endtask

    task automatic chk_p0(input string name, input logic [3:0] exp);
        check(name, 32'(bus.joy_out[3:0]), 32'(exp));
    endtask

    int  hold [NP];
    bit  seen_chg;
    logic [3:0] cur;

    initial begin : stim
        reset_n     = 1'b0;
        bus.joy_in  = '0;
        bus.mode    = 2'd0;
        bus.dis     = '0;
        wait_n(3);
        chk_en = 1'b1;
        check("reset_joy_out", 32'(bus.joy_out), 32'd0);
        check("reset_chg", 32'(bus.chg), 32'd0);
        reset_n = 1'b1;
        wait_n(10);

        // PASS latency: appears DEB_LEN+3 cycles after first sampling edge
        set_p(0, 4'b1000);
        wait_n(7);
        chk_p0("pass_before", 4'b0000);
        wait_n(1);
        chk_p0("pass_latency", 4'b1000);
        check("pass_chg_high", 32'(bus.chg), 32'b001);
        wait_n(1);
        check("pass_chg_low", 32'(bus.chg), 32'b000);
        set_p(0, 4'b0000);
        wait_n(12);

        // Bounce faster than the debounce window never gets through
        seen_chg = 1'b0;
        cur = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                cur[0] = ~cur[0];
                set_p(0, cur);
            end
            @(negedge clk);
            if (bus.chg != '0) seen_chg = 1'b1;
        end
        check("bounce_no_chg", 32'(seen_chg), 32'd0);
        chk_p0("bounce_out", 4'b0000);
        wait_n(12);

        // LAST
        bus.mode = 2'd1;
        wait_n(3);
        set_p(0, 4'b1000);
        wait_n(10);
        chk_p0("last_up", 4'b1000);
        set_p(0, 4'b1001);
        wait_n(8);
        chk_p0("last_add_pending", 4'b1000);
        wait_n(1);
        chk_p0("last_add_right", 4'b0001);
        set_p(0, 4'b1000);
        wait_n(8);
        chk_p0("last_release_gap", 4'b0000);
        wait_n(1);
        chk_p0("last_release_up", 4'b1000);
        set_p(0, 4'b0000);
        wait_n(12);

        // FIRST
        bus.mode = 2'd2;
        wait_n(3);
        set_p(0, 4'b0010);
        wait_n(10);
        chk_p0("first_left", 4'b0010);
        set_p(0, 4'b0110);
        wait_n(10);
        chk_p0("first_ignore_down", 4'b0010);
        set_p(0, 4'b0100);
        wait_n(8);
        chk_p0("first_release_gap", 4'b0000);
        wait_n(1);
        chk_p0("first_release_down", 4'b0100);
        set_p(0, 4'b0000);
        wait_n(12);

        // SOCD
        bus.mode = 2'd3;
        wait_n(3);
        set_p(0, 4'b1100);
        wait_n(10);
        chk_p0("socd_ud", 4'b0000);
        set_p(0, 4'b0011);
        wait_n(10);
        chk_p0("socd_lr", 4'b0000);
        set_p(0, 4'b1001);
        wait_n(10);
        chk_p0("socd_diag", 4'b1001);
        set_p(0, 4'b0000);
        wait_n(12);
        bus.mode = 2'd1;
        wait_n(3);
        set_p(0, 4'b0011);
        wait_n(10);
        chk_p0("last_simul_lr", 4'b0010);
        set_p(0, 4'b0000);
        wait_n(12);

        // Bypass on player 1, then reset mid-debounce
        bus.dis = 3'b010;
        wait_n(3);
        for (int p = 0; p < NP; p++) set_p(p, 4'b1010);
        wait_n(10);
        check("dis_mix", 32'(bus.joy_out), 32'(12'b1000_1010_1000));
        set_p(0, 4'b0100);
        wait_n(3);
        reset_n = 1'b0;
        wait_n(1);
        check("midreset_joy_out", 32'(bus.joy_out), 32'd0);
        check("midreset_chg", 32'(bus.chg), 32'd0);
        reset_n = 1'b1;
        wait_n(7);
        check("requal_before", 32'(bus.joy_out), 32'd0);
        wait_n(1);
        check("requal_after", 32'(bus.joy_out), 32'(12'b1000_1010_0100));
        check("requal_chg", 32'(bus.chg), 32'b111);
        wait_n(5);

        // Randomised traffic, checked every cycle against the model
        bus.dis = '0;
        for (int p = 0; p < NP; p++) hold[p] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (hold[p] == 0) begin
                    set_p(p, 4'($urandom_range(0, 15)));
                    hold[p] = int'($urandom_range(1, 3 * DL));
                end else begin
                    hold[p]--;
                end
            end
            if ($urandom_range(0, 199) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) bus.dis = 3'($urandom_range(0, 7));
            reset_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        reset_n = 1'b1;
        wait_n(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
